// File: rtl/btn_conditioner.sv
// Pushbutton input stage: per-bit 2-flop synchroniser, debounce filter and
// registered press/release/auto-repeat strobes for the scene logic.
module btn_conditioner #(
    parameter int N_BTN         = 9,
    parameter int DEBOUNCE_CYC  = 250000,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 2500000,
    parameter int REPEAT_EN     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_BTN-1:0]   btn_raw,
    output logic [N_BTN-1:0]   btn_level,
    output logic [N_BTN-1:0]   btn_press,
    output logic [N_BTN-1:0]   btn_release,
    output logic [N_BTN-1:0]   btn_repeat,
    output logic [2*N_BTN-1:0] rpt_state_dbg
);

    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_REPT  = 2'd2
    } rpt_state_t;

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic [N_BTN-1:0] rise_acc;
    logic [N_BTN-1:0] fall_acc;

    rpt_state_t       state_q [N_BTN];
    rpt_state_t       state_d [N_BTN];
    logic [RP_W-1:0]  rcnt_q  [N_BTN];
    logic [RP_W-1:0]  rcnt_d  [N_BTN];
    logic [N_BTN-1:0] rpt_d;

    // A change is accepted on the edge where the disagreement reaches its terminal count.
    always_comb begin
        rise_acc = '0;
        fall_acc = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if ((sync2[i] != btn_level[i]) && (db_cnt[i] == DB_LAST)) begin
                rise_acc[i] = sync2[i];
                fall_acc[i] = ~sync2[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1       <= btn_raw;
            sync2       <= sync1;
            btn_press   <= rise_acc;
            btn_release <= fall_acc;
            btn_level   <= (btn_level | rise_acc) & ~fall_acc;
            for (int i = 0; i < N_BTN; i++) begin
                // Any return to agreement discards progress, so glitches never accumulate.
                if ((sync2[i] == btn_level[i]) || (db_cnt[i] == DB_LAST)) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_repeat <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= RPT_IDLE;
                rcnt_q[i]  <= '0;
            end
        end else begin
            btn_repeat <= rpt_d;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                rcnt_q[i]  <= rcnt_d[i];
            end
        end
    end

    // A release arriving on a repeat tick suppresses that tick.
    always_comb begin
        rpt_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            if (REPEAT_EN != 0) begin
                case (state_q[i])
                    RPT_IDLE: begin
                        if (rise_acc[i]) begin
                            state_d[i] = RPT_DELAY;
                            rcnt_d[i]  = '0;
                            rpt_d[i]   = 1'b1;
                        end
                    end
                    RPT_DELAY: begin
                        if (fall_acc[i]) begin
                            state_d[i] = RPT_IDLE;
                            rcnt_d[i]  = '0;
                        end else if (rcnt_q[i] == DELAY_LAST) begin
                            state_d[i] = RPT_REPT;
                            rcnt_d[i]  = '0;
                            rpt_d[i]   = 1'b1;
                        end else begin
                            rcnt_d[i]  = rcnt_q[i] + 1'b1;
                        end
                    end
                    RPT_REPT: begin
                        if (fall_acc[i]) begin
                            state_d[i] = RPT_IDLE;
                            rcnt_d[i]  = '0;
                        end else if (rcnt_q[i] == PERIOD_LAST) begin
                            rcnt_d[i]  = '0;
                            rpt_d[i]   = 1'b1;
                        end else begin
                            rcnt_d[i]  = rcnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = RPT_IDLE;
                        rcnt_d[i]  = '0;
                    end
                endcase
            end else begin
                state_d[i] = RPT_IDLE;
                rcnt_d[i]  = '0;
            end
        end
    end

    always_comb begin
        rpt_state_dbg = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rpt_state_dbg[2*i +: 2] = state_q[i];
        end
    end

endmodule
